run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
- Parametrised successor to the fixed 4-in-a-row sequence detector.
- Detects a run of identical consecutive bits on serial input w, with separately programmable lengths for 0-runs and 1-runs.
- Adds a sample enable, a sticky or one-shot output mode, and run-length status outputs.
- Sits on the serial-input path feeding the pattern/alarm logic. Moore-style registered outputs.

Parameters:
- MAX_RUN, 15, largest programmable run length (must be >= 2).
- CNT_W, $clog2(MAX_RUN+1), counter/length width (derived, not overridden).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  sample qualifier; w is consumed only on edges where en=1
- w  in  1  serial data bit
- len0  in  CNT_W  required 0-run length; 0 = 0-detection disabled
- len1  in  CNT_W  required 1-run length; 0 = 1-detection disabled
- mode  in  1  0 = sticky (z held while run continues), 1 = one-shot (single-cycle pulse per run)
- z  out  1  z0 | z1
- z0  out  1  0-run detected
- z1  out  1  1-run detected
- run_val  out  1  bit value of current run
- run_cnt  out  CNT_W  length of current run, saturating at MAX_RUN

Behaviour:
- Clock and reset: clk only; reset is synchronous and active-high. On rst: state=IDLE, run_cnt=0, run_val=0, z=z0=z1=0. rst overrides en and w, including mid-run, with no carry-over.
- States (package enum): IDLE (no bit sampled since reset), RUN (counting, not detected), HIT (detected, sticky mode only).
- Edge with en=1, state IDLE: run_val<=w, run_cnt<=1.
- Edge with en=1, other states: if w==run_val, run_cnt<=min(run_cnt+1, MAX_RUN); else run_val<=w, run_cnt<=1 (new run).
- Detection uses the new values: L = (new run_val ? len1 : len0).
- Sticky mode: next state HIT when L!=0 and new run_cnt>=L, otherwise RUN.
- One-shot mode: pulse when L!=0 and new run_cnt==L. State stays RUN. No re-pulse until the run breaks and a fresh run reaches L again.
- Outputs are registered and update at the same edge that samples the L-th matching bit. There is no extra cycle of latency.
- z0 = hit & ~run_val; z1 = hit & run_val. z0 and z1 are never both 1.
- Edge with en=0: state, run_val and run_cnt hold. Sticky mode: z/z0/z1 hold. One-shot mode: z/z0/z1 clear to 0.
- Saturation: run_cnt stops at MAX_RUN. Sticky detection stays asserted past saturation. One-shot cannot re-fire because run_cnt==L is not re-entered.
- len0/len1 changes: sampled only at en=1 edges; they take effect on the next sampled bit. Lowering L below the current run_cnt in sticky mode asserts at the next matching sample. In one-shot mode it does not assert until the next run.
- Values of len above MAX_RUN can never be reached, so no detection occurs.
- mode change mid-run: takes effect at the next en=1 edge. Switching from 1 to 0 with run_cnt>=L asserts at that edge.
- Run break from HIT: the opposite bit drops detection in the same edge, unless L for the new bit is 1.
- w must be 0/1. No X propagation handling is required.
- Compatibility: MAX_RUN>=4, len0=len1=4, mode=0, en=1 reproduces the legacy 4-zeros/4-ones detector cycle for cycle.

Decomposition:
- Package run_det_pkg holds the state enum {IDLE, RUN, HIT}, MODE_STICKY=1'b0 and MODE_ONESHOT=1'b1.
- One sub-module, run_counter: a saturating counter with load-to-1 and increment, parameter MAX_RUN.
- The FSM and output registers stay in the top level.

Test Plan:
- Legacy check: len0=len1=4, mode=0, en=1, w=0,0,0,0,0,1 -> z0 rises at the edge sampling the 4th 0, holds for the 5th, drops at the 1. z1=0 throughout.
- One-shot: len1=3, mode=1, w=1 x6 then 0 then 1 x3 -> z1 is a single-cycle pulse at the 3rd 1, no pulse for the 4th–6th, a second pulse at the 3rd 1 of the new run.
- Enable gating: len0=2, en toggles 1,0,1 with w=0 at each en=1 edge -> run_cnt 1,1,2; z0 rises only at the second enabled edge. In one-shot mode it pulses there and clears during en=0.
- Saturation and disable: MAX_RUN=15, len1=15, w=1 x20 -> run_cnt stops at 15, z1 high from the 15th bit onward. Then len1=0 -> z1 drops at the next sampled 1.
- Length 1 and alternation: len0=len1=1, mode=0, w=0,1,0,1 -> z stays high every cycle, with z0/z1 alternating.
- Reset mid-run: after 3 ones with len1=4, assert rst for one edge, then send one 1 -> run_cnt=1, z1=0. Three more ones are needed before z1 asserts.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types for the run-length detector: FSM state encoding and output-mode constants.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } state_e;

    localparam logic MODE_STICKY  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/run_counter.sv
// Saturating run-length counter: load starts a fresh run at 1, inc extends it up to MAX_RUN.
// cnt_next exposes the value the counter takes at the coming edge so detection can use it.
module run_counter #(
    parameter  int MAX_RUN = 15,
    localparam int CNT_W   = $clog2(MAX_RUN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_next,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: cnt_d gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(1);
        end else if (inc && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next = cnt_d;
    assign cnt      = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// Detects runs of identical bits on w with separate programmable 0-run and 1-run lengths,
// sticky or one-shot registered outputs, and run value/length status.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter  int MAX_RUN = 15,
    localparam int CNT_W   = $clog2(MAX_RUN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic             mode,
    output logic             z,
    output logic             z0,
    output logic             z1,
    output logic             run_val,
    output logic [CNT_W-1:0] run_cnt
);

    state_e           state_d, state_q;
    logic             run_val_d, run_val_q;
    logic             z_d, z_q;
    logic             z0_d, z0_q;
    logic             z1_d, z1_q;
    logic             load, inc, hit;
    logic [CNT_W-1:0] len_sel;
    logic [CNT_W-1:0] cnt_next;

    assign load = en && ((state_q == IDLE) || (w != run_val_q));
    assign inc  = en && !load;

    run_counter #(
        .MAX_RUN (MAX_RUN)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (inc),
        .cnt_next (cnt_next),
        .cnt      (run_cnt)
    );

    always_comb begin
        state_d   = state_q;
        run_val_d = run_val_q;
        z0_d      = z0_q;
        z1_d      = z1_q;
        hit       = 1'b0;
        len_sel   = '0;
        if (en) begin
            run_val_d = w;
            len_sel   = w ? len1 : len0;
            if (mode == MODE_STICKY) begin
                hit     = (len_sel != '0) && (cnt_next >= len_sel);
                state_d = hit ? HIT : RUN;
            end else begin
                // Fire only on entering L: a fresh run, or a continuing run that was still below L.
                hit     = (len_sel != '0) && (cnt_next == len_sel) && (load || (run_cnt < len_sel));
                state_d = RUN;
            end
            z0_d = hit & ~w;
            z1_d = hit & w;
        end else if (mode == MODE_ONESHOT) begin
            z0_d = 1'b0;
            z1_d = 1'b0;
        end
        z_d = z0_d | z1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_val_q <= 1'b0;
            z_q       <= 1'b0;
            z0_q      <= 1'b0;
            z1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_val_q <= run_val_d;
            z_q       <= z_d;
            z0_q      <= z0_d;
            z1_q      <= z1_d;
        end
    end

    assign z       = z_q;
    assign z0      = z0_q;
    assign z1      = z1_q;
    assign run_val = run_val_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector: each driven cycle pushes its expected outputs,
// which are popped and compared one cycle later, after the sampling edge.
module tb_run_length_detector;

    typedef struct packed {
        logic       z;
        logic       z0;
        logic       z1;
        logic       val;
        logic [3:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic [3:0] len0 = 4'd0;
    logic [3:0] len1 = 4'd0;
    logic       mode = 1'b0;
    logic       z, z0, z1, run_val;
    logic [3:0] run_cnt;

    obs_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    run_length_detector #(.MAX_RUN(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .w       (w),
        .len0    (len0),
        .len1    (len1),
        .mode    (mode),
        .z       (z),
        .z0      (z0),
        .z1      (z1),
        .run_val (run_val),
        .run_cnt (run_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input logic ez0, input logic ez1, input logic ev, input int ec);
        return '{z: ez0 | ez1, z0: ez0, z1: ez1, val: ev, cnt: 4'(ec)};
    endfunction

    // Drive one cycle, queue its expectation, and land #1 after the sampling edge.
    task automatic apply(input logic r, input logic e, input logic ww, input obs_t x);
        rst = r;
        en  = e;
        w   = ww;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe();
        return {z, z0, z1, run_val, run_cnt};
    endfunction

    task automatic quiet_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, x;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b1, ex(0, 0, 0, 0));
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got %b expected %b", i, got, x);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_legacy();
        logic wv[6] = '{0, 0, 0, 0, 0, 1};
        obs_t xv[6];
        obs_t got, x;
        xv = '{ex(0,0,0,1), ex(0,0,0,2), ex(0,0,0,3), ex(1,0,0,4), ex(1,0,0,5), ex(0,0,1,1)};
        quiet_reset();
        len0 = 4'd4; len1 = 4'd4; mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, wv[i], xv[i]);
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL legacy[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    task automatic test_oneshot();
        obs_t got, x;
        quiet_reset();
        len0 = 4'd4; len1 = 4'd3; mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 6)       apply(1'b0, 1'b1, 1'b1, ex(0, i == 2, 1, i + 1));
            else if (i == 6) apply(1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1));
            else             apply(1'b0, 1'b1, 1'b1, ex(0, i == 9, 1, i - 6));
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL oneshot[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    task automatic test_enable();
        logic ev[4] = '{1, 0, 1, 0};
        obs_t xs[4], xo[4];
        obs_t got, x;
        xs = '{ex(0,0,0,1), ex(0,0,0,1), ex(1,0,0,2), ex(1,0,0,2)};
        xo = '{ex(0,0,0,1), ex(0,0,0,1), ex(1,0,0,2), ex(0,0,0,2)};
        len0 = 4'd2; len1 = 4'd0;
        for (int m = 0; m < 2; m++) begin
            quiet_reset();
            mode = 1'(m);
            for (int i = 0; i < 4; i++) begin
                // w=1 while disabled must not disturb the 0-run.
                apply(1'b0, ev[i], ~ev[i], (m == 0) ? xs[i] : xo[i]);
                got = observe();
                x   = exp_q.pop_front();
                tests_run++;
                if (got !== x) begin
                    tests_failed++;
                    $display("FAIL enable_m%0d[%0d]: got %b expected %b", m, i, got, x);
                end
            end
        end
    endtask

    task automatic test_saturation();
        obs_t got, x;
        quiet_reset();
        len0 = 4'd0; len1 = 4'd15; mode = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            if (i == 21) len1 = 4'd0;
            apply(1'b0, 1'b1, 1'b1, ex(0, (i >= 15) && (i <= 20), 1, (i > 15) ? 15 : i));
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL sat_sticky[%0d]: got %b expected %b", i, got, x);
            end
        end
        quiet_reset();
        len1 = 4'd15; mode = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            apply(1'b0, 1'b1, 1'b1, ex(0, i == 15, 1, (i > 15) ? 15 : i));
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL sat_oneshot[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    task automatic test_len_one_alternate();
        obs_t got, x;
        quiet_reset();
        len0 = 4'd1; len1 = 4'd1; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'(i % 2), ex(i % 2 == 0, i % 2 == 1, 1'(i % 2), 1));
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL alternate[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic mv[6] = '{1, 1, 1, 1, 0, 0};
        logic wv[6] = '{0, 0, 0, 0, 0, 1};
        obs_t xv[6];
        obs_t got, x;
        xv = '{ex(0,0,0,1), ex(0,0,0,2), ex(1,0,0,3), ex(0,0,0,4), ex(1,0,0,5), ex(0,1,1,1)};
        quiet_reset();
        len0 = 4'd3; len1 = 4'd1;
        for (int i = 0; i < 6; i++) begin
            mode = mv[i];
            apply(1'b0, 1'b1, wv[i], xv[i]);
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL mode_switch[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic rv[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        obs_t xv[8];
        obs_t got, x;
        xv = '{ex(0,0,1,1), ex(0,0,1,2), ex(0,0,1,3), ex(0,0,0,0),
               ex(0,0,1,1), ex(0,0,1,2), ex(0,0,1,3), ex(0,1,1,4)};
        quiet_reset();
        len0 = 4'd4; len1 = 4'd4; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply(rv[i], 1'b1, 1'b1, xv[i]);
            got = observe();
            x   = exp_q.pop_front();
            tests_run++;
            if (got !== x) begin
                tests_failed++;
                $display("FAIL reset_mid_run[%0d]: got %b expected %b", i, got, x);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_legacy();
        test_oneshot();
        test_enable();
        test_saturation();
        test_len_one_alternate();
        test_mode_switch();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
